edge_event_logger: RTL and testbench

EDGE_EVENT_LOGGER -- requirements
Module: edge_event_logger

---
 rtl/edge_event_logger_pkg.sv | 33 +++
 rtl/edge_event_fifo.sv | 61 ++++++
 rtl/edge_event_logger.sv | 123 ++++++++++++
 tb/tb_edge_event_logger.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_event_logger_pkg.sv
// Shared types and constants for the edge event logger: edge modes,
// FIFO entry layout and uio bit positions.
package edge_event_logger_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

   localparam int unsigned TS_W = 8;
   localparam int unsigned CH_W = 2;

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic            multi;
      logic [TS_W-1:0] ts;
   } entry_t;

   localparam int unsigned ENTRY_W = $bits(entry_t);

   localparam int unsigned UIO_POP   = 0;
   localparam int unsigned UIO_CLR   = 1;
   localparam int unsigned UIO_VALID = 2;
   localparam int unsigned UIO_FULL  = 3;
   localparam int unsigned UIO_OVF   = 4;
   localparam int unsigned UIO_MULTI = 5;
   localparam int unsigned UIO_CH_LO = 6;

   localparam logic [7:0] UIO_OE_MASK = 8'hFC;

endpackage

// File: rtl/edge_event_fifo.sv
// Event FIFO with occupancy count, sticky overflow and synchronous clear.
module edge_event_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));

   // When full, a push is only accepted alongside a real pop: the new entry
   // lands in the slot being vacated by the head.
   assign do_pop  = pop && !empty && !clear;
   assign do_push = push && !clear && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
         if (push && full && !do_pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/edge_event_logger.sv
// Timestamped edge logger: synchronised channel inputs feed an event FIFO
// whose head entry is presented on uo_out/uio_out.
module edge_event_logger
   import edge_event_logger_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned TS_BITS  = TS_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned SW = CHANNELS + 2;

   // Channels, pop and clear share one synchroniser chain: {clr, pop, ch}.
   logic [SW-1:0]       raw, sync1, sync2, sync_d;
   logic [CHANNELS-1:0] ch_now, ch_prev, rise, fall, qual;
   logic                pop_s, pop_prev, clr_s;
   logic                push, pop_req, found, multi;
   logic [CH_W-1:0]     first_ch;
   logic [TS_BITS-1:0]  ts_cnt;
   edge_mode_e          mode;
   entry_t              new_entry, head;
   logic                full, empty, overflow, valid;
   logic                unused_bits;

   assign raw = {uio_in[UIO_CLR], uio_in[UIO_POP], ui_in[CHANNELS-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         sync_d <= '0;
      end else begin
         sync1  <= raw;
         sync2  <= sync1;
         sync_d <= sync2;
      end
   end

   assign ch_now   = sync2[CHANNELS-1:0];
   assign ch_prev  = sync_d[CHANNELS-1:0];
   assign pop_s    = sync2[CHANNELS];
   assign pop_prev = sync_d[CHANNELS];
   assign clr_s    = sync2[CHANNELS+1];
   assign mode     = edge_mode_e'(ui_in[5:4]);
   assign rise     = ch_now & ~ch_prev;
   assign fall     = ~ch_now & ch_prev;

   always_comb begin
      case (mode)
         EDGE_RISE: qual = rise;
         EDGE_FALL: qual = fall;
         EDGE_BOTH: qual = rise | fall;
         default:   qual = '0;
      endcase
   end

   always_comb begin
      first_ch = '0;
      found    = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (qual[i] && !found) begin
            first_ch = CH_W'(i);
            found    = 1'b1;
         end
      end
   end

   assign multi   = |(qual & (qual - 1'b1));
   assign push    = ena && !clr_s && (|qual);
   assign pop_req = pop_s && !pop_prev && !clr_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ts_cnt <= '0;
      else if (clr_s)  ts_cnt <= '0;
      else if (ena)    ts_cnt <= ts_cnt + 1'b1;
   end

   assign new_entry = '{ch: first_ch, multi: multi, ts: ts_cnt};

   edge_event_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop_req),
      .clear    (clr_s),
      .din      (new_entry),
      .dout     (head),
      .full     (full),
      .empty    (empty),
      .overflow (overflow)
   );

   assign valid  = !empty;
   assign uo_out = valid ? head.ts : '0;

   always_comb begin
      uio_out            = '0;
      uio_out[UIO_VALID] = valid;
      uio_out[UIO_FULL]  = full;
      uio_out[UIO_OVF]   = overflow;
      if (valid) begin
         uio_out[UIO_MULTI]          = head.multi;
         uio_out[UIO_CH_LO +: CH_W]  = head.ch;
      end
   end

   assign uio_oe = UIO_OE_MASK;

   assign unused_bits = ^{ui_in, uio_in, sync_d[CHANNELS+1]};

endmodule

// File: tb/tb_edge_event_logger.sv
// Directed self-checking bench for edge_event_logger (CHANNELS=4, DEPTH=8).
module tb_edge_event_logger;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Reference timestamp counter and its clear synchroniser copy.
   logic [7:0] m_cnt;
   logic       clr_d1, clr_d2;
   logic [7:0] ts_q [9];
   logic [7:0] t, t2;

   always #5 clk = ~clk;

   edge_event_logger #(
      .CHANNELS (4),
      .DEPTH    (8),
      .TS_BITS  (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (clr_d2)   m_cnt = 8'd0;
      else if (ena) m_cnt = m_cnt + 8'd1;
      clr_d2 = clr_d1;
      clr_d1 = uio_in[1];
      #1;
   endtask

   // One-cycle pulse on the masked channels; push lands on the third tick.
   task automatic ev(input logic [3:0] mask, output logic [7:0] ts);
      ui_in[3:0] = mask;
      tick();
      ts = m_cnt + 8'd1;
      ui_in[3:0] = 4'h0;
      tick(); tick(); tick();
   endtask

   task automatic pop();
      uio_in[0] = 1'b1;
      tick();
      uio_in[0] = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic clear_fifo();
      uio_in[1] = 1'b1;
      tick(); tick(); tick();
      uio_in[1] = 1'b0;
      tick(); tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h10;
      uio_in = 8'h00;
      m_cnt  = 8'd0;
      clr_d1 = 1'b0;
      clr_d2 = 1'b0;
      #12;
      chk("reset_uo_out", uo_out, 8'h00);
      chk("reset_uio_out", uio_out, 8'h00);
      chk("reset_uio_oe", uio_oe, 8'hFC);
      rst_n = 1'b1;

      // Rising pulse on ch2 sampled when the counter becomes 10.
      while (m_cnt != 8'd9) tick();
      ui_in[2] = 1'b1;
      tick();
      ui_in[2] = 1'b0;
      tick();
      chk("t1_not_yet_valid", uio_out, 8'h00);
      tick();
      chk("t1_ts", uo_out, 8'h0B);
      chk("t1_flags", uio_out, 8'h84);
      tick(); tick(); tick();
      pop();
      chk("t1_single_entry", uio_out, 8'h00);
      chk("t1_empty_ts", uo_out, 8'h00);

      // Both-edge mode, ch1 and ch3 together.
      ui_in = 8'h3A;
      tick();
      t = m_cnt + 8'd1;
      tick(); tick();
      chk("t2_rise_ts", uo_out, t);
      chk("t2_rise_flags", uio_out, 8'h64);
      ui_in = 8'h30;
      tick();
      t2 = m_cnt + 8'd1;
      tick(); tick(); tick();
      pop();
      chk("t2_fall_ts", uo_out, t2);
      chk("t2_fall_flags", uio_out, 8'h64);
      pop();
      chk("t2_empty", uio_out, 8'h00);
      ui_in = 8'h12;
      tick();
      t = m_cnt + 8'd1;
      tick(); tick();
      chk("t2_mode01_rise_ts", uo_out, t);
      chk("t2_mode01_rise_flags", uio_out, 8'h44);
      ui_in = 8'h10;
      tick(); tick(); tick(); tick();
      pop();
      chk("t2_mode01_fall_ignored", uio_out, 8'h00);

      // Fill to full, then one overflowing event.
      for (int i = 0; i < 8; i++) ev(4'h1, ts_q[i]);
      chk("t3_full", uio_out, 8'h0C);
      chk("t3_head", uo_out, ts_q[0]);
      ev(4'h1, ts_q[8]);
      chk("t3_overflow", uio_out, 8'h1C);
      chk("t3_head_kept", uo_out, ts_q[0]);
      for (int i = 0; i < 8; i++) begin
         chk("t3_seq", uo_out, ts_q[i]);
         pop();
      end
      chk("t3_drained", uio_out, 8'h10);
      chk("t3_drained_ts", uo_out, 8'h00);
      pop();
      chk("t3_pop_empty", uio_out, 8'h10);

      // Full FIFO with simultaneous push and pop.
      clear_fifo();
      chk("t4_cleared", uio_out, 8'h00);
      for (int i = 0; i < 8; i++) ev(4'h1, ts_q[i]);
      ui_in[0]  = 1'b1;
      uio_in[0] = 1'b1;
      tick();
      ts_q[8] = m_cnt + 8'd1;
      ui_in[0]  = 1'b0;
      uio_in[0] = 1'b0;
      tick(); tick();
      chk("t4_flags", uio_out, 8'h0C);
      chk("t4_head_adv", uo_out, ts_q[1]);
      tick();
      for (int i = 1; i < 9; i++) begin
         chk("t4_seq", uo_out, ts_q[i]);
         pop();
      end
      chk("t4_drained", uio_out, 8'h00);

      // Counter wrap, then ena low freezes counter and capture.
      while (m_cnt != 8'd253) tick();
      ev(4'h1, t);
      chk("t5_wrap_ts", uo_out, 8'hFF);
      ev(4'h1, t2);
      pop();
      chk("t5_after_wrap_ts", uo_out, 8'h03);
      pop();
      chk("t5_empty", uio_out, 8'h00);
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ui_in[3:0] = ((i % 2) != 0) ? 4'hF : 4'h0;
         tick();
      end
      ui_in[3:0] = 4'h0;
      tick(); tick(); tick();
      chk("t5_ena_off_no_push", uio_out, 8'h00);
      ena = 1'b1;
      ev(4'h1, t);
      chk("t5_frozen_ts", uo_out, 8'h0F);
      pop();

      // Clear with five entries and overflow set.
      for (int i = 0; i < 9; i++) ev(4'h1, ts_q[i]);
      pop(); pop(); pop();
      chk("t6_pre_flags", uio_out, 8'h14);
      chk("t6_pre_head", uo_out, ts_q[3]);
      clear_fifo();
      chk("t6_clear_flags", uio_out, 8'h00);
      chk("t6_clear_ts", uo_out, 8'h00);
      ev(4'h1, t);
      chk("t6_ts_after_clear", uo_out, 8'h02);
      chk("t6_flags_after_clear", uio_out, 8'h04);

      // Asynchronous reset mid-stream with a half-captured event.
      ui_in[0] = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_uo_out", uo_out, 8'h00);
      chk("t6_rst_uio_out", uio_out, 8'h00);
      chk("t6_rst_uio_oe", uio_oe, 8'hFC);
      ui_in  = 8'h18;
      m_cnt  = 8'd0;
      clr_d1 = 1'b0;
      clr_d2 = 1'b0;
      #1;
      rst_n = 1'b1;
      tick(); tick();
      chk("t6_held_high_pending", uio_out, 8'h00);
      tick();
      chk("t6_held_high_ts", uo_out, 8'h02);
      chk("t6_held_high_flags", uio_out, 8'hC4);
      ui_in = 8'h10;
      tick(); tick(); tick(); tick();
      pop();
      chk("t6_only_one_entry", uio_out, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
